spi_regfile_periph: RTL and testbench



---
 rtl/spi_regfile_pkg.sv | 22 ++
 rtl/spi_regfile_periph_if.sv | 14 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_regfile_periph.sv | 210 +++++++++++++++++++++
 tb/tb_spi_regfile_periph.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
`timescale 1ns/1ps
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } state_e;

  localparam logic CMD_WRITE = 1'b1;

  // Burst address step: the last real register wraps to 0; out-of-range
  // addresses keep counting and the caller truncates to the header width.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [31:0] num_regs);
    if (addr == num_regs - 32'd1) next_addr = '0;
    else                          next_addr = addr + 32'd1;
  endfunction

endpackage

// File: rtl/spi_regfile_periph_if.sv
// SPI pin bundle between a controller (master) and the register peripheral (slave).
`timescale 1ns/1ps
interface spi_regfile_periph_if;
  // No valid/ready here: a transfer is framed by ncs low, copi is sampled and
  // cipo is consumed on sclk rise, and the peripheral updates cipo on sclk fall.
  logic sclk;
  logic ncs;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, ncs, copi, input cipo, cipo_oe);
  modport slave  (input sclk, ncs, copi, output cipo, cipo_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with an extra history flop for rise/fall pulses.
`timescale 1ns/1ps
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral giving burst read/write access to a small register bank.
`timescale 1ns/1ps
module spi_regfile_periph
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_regfile_periph_if.slave        spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_strobe_o,
  output logic                       err_o,
  output state_e                     state_o
);

  localparam int CNT_W = $clog2(ADDR_W + DATA_W + 1);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic copi_lvl, copi_rise_unused, copi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(spi.sclk),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d(spi.ncs),
    .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d(spi.copi),
    .level(copi_lvl), .rise(copi_rise_unused), .fall(copi_fall_unused)
  );

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   hdr_sr_q;
  logic [ADDR_W:0]     hdr_nxt;
  logic [DATA_W-1:0]   data_sr_q, data_nxt, out_sr_q, out_shift;
  logic [ADDR_W-1:0]   addr_q, addr_inc;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   rd_cur, rd_inc;
  logic                cur_ok, inc_ok;
  logic                commit_q, load_q, rd_armed_q, rd_last_q, cipo_q, err_q;
  logic [NUM_REGS-1:0] strobe_q;
  logic                sclk_rise_v, sclk_fall_v, partial;

  // An ncs rise in the same cycle as an sclk edge suppresses the edge.
  assign sclk_rise_v = sclk_rise & ~ncs_rise;
  assign sclk_fall_v = sclk_fall & ~ncs_rise;
  assign hdr_nxt     = {hdr_sr_q, copi_lvl};
  assign data_nxt    = {data_sr_q[DATA_W-2:0], copi_lvl};
  assign out_shift   = out_sr_q << 1;
  assign partial     = ((state_q == HDR) || (state_q == WR)) && (cnt_q != '0);
  assign addr_inc    = ADDR_W'(next_addr(32'(addr_q), 32'(NUM_REGS)));
  assign cur_ok      = 32'(addr_q)   < 32'(NUM_REGS);
  assign inc_ok      = 32'(addr_inc) < 32'(NUM_REGS);

  // Read-back values at the current and the next burst address; 0 when out of range.
  always_comb begin
    rd_cur = '0;
    rd_inc = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q   == ADDR_W'(i)) rd_cur = regs_q[i];
      if (addr_inc == ADDR_W'(i)) rd_inc = regs_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ncs_fall) state_d = HDR;
      HDR: begin
        if (ncs_rise) state_d = IDLE;
        else if (sclk_rise_v && (cnt_q == CNT_W'(ADDR_W)))
          state_d = (hdr_nxt[ADDR_W] == CMD_WRITE) ? WR : RD;
      end
      WR:      if (ncs_rise) state_d = IDLE;
      RD:      if (ncs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      hdr_sr_q   <= '0;
      data_sr_q  <= '0;
      out_sr_q   <= '0;
      addr_q     <= '0;
      commit_q   <= 1'b0;
      load_q     <= 1'b0;
      rd_armed_q <= 1'b0;
      rd_last_q  <= 1'b0;
      cipo_q     <= 1'b0;
      err_q      <= 1'b0;
      strobe_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      strobe_q <= '0;
      err_q    <= 1'b0;
      commit_q <= 1'b0;
      load_q   <= 1'b0;

      if (commit_q) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (addr_q == ADDR_W'(i)) begin
            regs_q[i]   <= data_sr_q;
            strobe_q[i] <= 1'b1;
          end
        end
        if (!cur_ok) err_q <= 1'b1;
        addr_q <= addr_inc;
      end

      if (load_q) begin
        out_sr_q <= rd_cur;
        cipo_q   <= rd_cur[DATA_W-1];
        if (!cur_ok) err_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (ncs_fall) begin
            cnt_q      <= '0;
            hdr_sr_q   <= '0;
            data_sr_q  <= '0;
            rd_armed_q <= 1'b0;
            rd_last_q  <= 1'b0;
          end
        end
        HDR: begin
          if (sclk_rise_v) begin
            hdr_sr_q <= hdr_nxt[ADDR_W-1:0];
            if (cnt_q == CNT_W'(ADDR_W)) begin
              cnt_q  <= '0;
              addr_q <= hdr_nxt[ADDR_W-1:0];
              load_q <= (hdr_nxt[ADDR_W] != CMD_WRITE);
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        WR: begin
          if (sclk_rise_v) begin
            data_sr_q <= data_nxt;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_q    <= '0;
              commit_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        RD: begin
          // Only falls that follow a data rise shift; the header's last fall is skipped.
          if (sclk_rise_v) begin
            rd_armed_q <= 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_q     <= '0;
              rd_last_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else if (sclk_fall_v && rd_armed_q) begin
            rd_armed_q <= 1'b0;
            if (rd_last_q) begin
              rd_last_q <= 1'b0;
              addr_q    <= addr_inc;
              out_sr_q  <= rd_inc;
              cipo_q    <= rd_inc[DATA_W-1];
              if (!inc_ok) err_q <= 1'b1;
            end else begin
              out_sr_q <= out_shift;
              cipo_q   <= out_shift[DATA_W-1];
            end
          end
        end
        default: ;
      endcase

      if (ncs_rise) begin
        cnt_q <= '0;
        if (partial) err_q <= 1'b1;
      end
      if (ncs_lvl) cipo_q <= 1'b0;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_o[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign wr_strobe_o = strobe_q;
  assign err_o       = err_q;
  assign state_o     = state_q;
  assign spi.cipo    = cipo_q & ~ncs_lvl;
  assign spi.cipo_oe = ~ncs_lvl;

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Directed bench for spi_regfile_periph: single/burst writes, reads, errors, reset.
`timescale 1ns/1ps
module tb_spi_regfile_periph;
  import spi_regfile_pkg::*;

  localparam int NUM_REGS = 5;
  localparam int DATA_W   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_REGS*DATA_W-1:0] regs_o;
  logic [NUM_REGS-1:0]        wr_strobe_o;
  logic                       err_o;
  state_e                     state_o;

  spi_regfile_periph_if spi();

  spi_regfile_periph #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(7), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi(spi),
    .regs_o(regs_o), .wr_strobe_o(wr_strobe_o), .err_o(err_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int err_total = 0;
  logic [NUM_REGS-1:0] strobe_log[$];
  logic [NUM_REGS-1:0] exp_q[$];

  // Every clk with err_o or a strobe high is logged, so a stretched pulse shows up twice.
  always @(negedge clk) begin
    if (err_o) err_total++;
    if (wr_strobe_o != '0) strobe_log.push_back(wr_strobe_o);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time exceeded, got hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    spi.copi = b;
    wait_clk(5);
    r = spi.cipo;
    spi.sclk = 1'b1;
    wait_clk(5);
    spi.sclk = 1'b0;
  endtask

  task automatic frame_start(input logic rw, input logic [6:0] addr);
    logic r;
    spi.ncs = 1'b0;
    wait_clk(5);
    spi_bit(rw, r);
    for (int i = 6; i >= 0; i--) spi_bit(addr[i], r);
  endtask

  task automatic spi_word(input logic [7:0] w, output logic [7:0] r);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(w[i], b);
      r[i] = b;
    end
  endtask

  task automatic frame_end();
    wait_clk(5);
    spi.ncs  = 1'b1;
    spi.copi = 1'b0;
    wait_clk(10);
  endtask

  task automatic test_reset();
    spi.ncs = 1'b1; spi.sclk = 1'b0; spi.copi = 1'b0;
    rst_n = 1'b0;
    wait_clk(3);
    tests++; if (regs_o !== 40'h0) begin fails++; $display("FAIL reset_regs: got %h expected 0", regs_o); end
    tests++; if (wr_strobe_o !== 5'b0) begin fails++; $display("FAIL reset_strobe: got %b expected 0", wr_strobe_o); end
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err_o); end
    tests++; if (spi.cipo !== 1'b0 || spi.cipo_oe !== 1'b0) begin fails++; $display("FAIL reset_cipo: got %b/%b expected 0/0", spi.cipo, spi.cipo_oe); end
    tests++; if (state_o !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", state_o, IDLE); end
    rst_n = 1'b1;
    wait_clk(5);
    tests++; if (state_o !== IDLE || spi.cipo_oe !== 1'b0) begin fails++; $display("FAIL post_reset_idle: got %0d/%b expected 0/0", state_o, spi.cipo_oe); end
  endtask

  task automatic test_write_single();
    int e0, s0;
    logic [7:0] r;
    e0 = err_total; s0 = strobe_log.size();
    frame_start(1'b1, 7'h02); spi_word(8'h80, r); frame_end();
    tests++; if (regs_o !== 40'h00_00_80_00_00) begin fails++; $display("FAIL single_regs: got %h expected 0000800000", regs_o); end
    tests++; if (strobe_log.size() - s0 != 1) begin fails++; $display("FAIL single_strobe_count: got %0d expected 1", strobe_log.size() - s0); end
    else begin
      tests++; if (strobe_log[s0] !== 5'b00100) begin fails++; $display("FAIL single_strobe: got %b expected 00100", strobe_log[s0]); end
    end
    tests++; if (err_total - e0 != 0) begin fails++; $display("FAIL single_err: got %0d expected 0", err_total - e0); end
  endtask

  task automatic test_burst_wrap();
    int e0, s0;
    logic [7:0] r;
    e0 = err_total; s0 = strobe_log.size();
    exp_q = {5'b01000, 5'b10000, 5'b00001};
    frame_start(1'b1, 7'h03);
    spi_word(8'h11, r); spi_word(8'h22, r); spi_word(8'h33, r);
    frame_end();
    tests++; if (regs_o !== 40'h22_11_80_00_33) begin fails++; $display("FAIL burst_regs: got %h expected 2211800033", regs_o); end
    tests++; if (strobe_log.size() - s0 != exp_q.size()) begin fails++; $display("FAIL burst_strobe_count: got %0d expected %0d", strobe_log.size() - s0, exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++; if (strobe_log[s0+i] !== exp_q[i]) begin fails++; $display("FAIL burst_strobe_%0d: got %b expected %b", i, strobe_log[s0+i], exp_q[i]); end
      end
    end
    tests++; if (err_total - e0 != 0) begin fails++; $display("FAIL burst_err: got %0d expected 0", err_total - e0); end
  endtask

  task automatic test_write_latency();
    int s0;
    logic r;
    logic [7:0] w;
    w = 8'hA5;
    s0 = strobe_log.size();
    frame_start(1'b1, 7'h01);
    for (int i = 7; i >= 1; i--) spi_bit(w[i], r);
    spi.copi = w[0];
    wait_clk(5);
    spi.sclk = 1'b1;
    wait_clk(3);
    tests++; if (regs_o[15:8] !== 8'h00) begin fails++; $display("FAIL latency_early: got %h expected 00", regs_o[15:8]); end
    wait_clk(1);
    tests++; if (regs_o[15:8] !== 8'hA5) begin fails++; $display("FAIL latency_on_time: got %h expected a5", regs_o[15:8]); end
    wait_clk(1);
    spi.sclk = 1'b0;
    frame_end();
    tests++; if (strobe_log.size() - s0 != 1 || strobe_log[s0] !== 5'b00010) begin fails++; $display("FAIL latency_strobe: got %0d entries expected one 00010", strobe_log.size() - s0); end
  endtask

  task automatic test_read_burst();
    int e0;
    logic [7:0] r0, r1;
    e0 = err_total;
    frame_start(1'b0, 7'h01);
    tests++; if (spi.cipo_oe !== 1'b1) begin fails++; $display("FAIL read_oe_selected: got %b expected 1", spi.cipo_oe); end
    spi_word(8'h00, r0); spi_word(8'h00, r1);
    frame_end();
    tests++; if (r0 !== 8'hA5) begin fails++; $display("FAIL read_word0: got %h expected a5", r0); end
    tests++; if (r1 !== 8'h80) begin fails++; $display("FAIL read_word1: got %h expected 80", r1); end
    tests++; if (spi.cipo_oe !== 1'b0 || spi.cipo !== 1'b0) begin fails++; $display("FAIL read_oe_deselected: got %b/%b expected 0/0", spi.cipo_oe, spi.cipo); end
    tests++; if (err_total - e0 != 0) begin fails++; $display("FAIL read_err: got %0d expected 0", err_total - e0); end
    tests++; if (regs_o !== 40'h22_11_80_A5_33) begin fails++; $display("FAIL read_regs_kept: got %h expected 221180a533", regs_o); end
  endtask

  task automatic test_read_wrap();
    logic [7:0] r0, r1;
    frame_start(1'b0, 7'h04);
    spi_word(8'h00, r0); spi_word(8'h00, r1);
    frame_end();
    tests++; if (r0 !== 8'h22 || r1 !== 8'h33) begin fails++; $display("FAIL read_wrap: got %h %h expected 22 33", r0, r1); end
  endtask

  task automatic test_out_of_range();
    int e0, s0;
    logic [7:0] r;
    e0 = err_total; s0 = strobe_log.size();
    frame_start(1'b1, 7'h10); spi_word(8'hFF, r); frame_end();
    tests++; if (regs_o !== 40'h22_11_80_A5_33) begin fails++; $display("FAIL oor_write_regs: got %h expected 221180a533", regs_o); end
    tests++; if (strobe_log.size() != s0) begin fails++; $display("FAIL oor_write_strobe: got %0d expected 0", strobe_log.size() - s0); end
    tests++; if (err_total - e0 != 1) begin fails++; $display("FAIL oor_write_err: got %0d expected 1", err_total - e0); end
    // 0x7F is out of range and its successor wraps to register 0, so exactly one error.
    e0 = err_total;
    frame_start(1'b0, 7'h7F); spi_word(8'h00, r); frame_end();
    tests++; if (r !== 8'h00) begin fails++; $display("FAIL oor_read7f_data: got %h expected 00", r); end
    tests++; if (err_total - e0 != 1) begin fails++; $display("FAIL oor_read7f_err: got %0d expected 1", err_total - e0); end
    e0 = err_total;
    frame_start(1'b0, 7'h10); spi_word(8'h00, r); frame_end();
    tests++; if (r !== 8'h00) begin fails++; $display("FAIL oor_read10_data: got %h expected 00", r); end
    tests++; if (err_total - e0 < 1) begin fails++; $display("FAIL oor_read10_err: got %0d expected at least 1", err_total - e0); end
  endtask

  task automatic test_partial_word();
    int e0, s0;
    logic [7:0] r;
    logic b;
    e0 = err_total; s0 = strobe_log.size();
    frame_start(1'b1, 7'h00);
    spi_word(8'h5A, r);
    spi_bit(1'b1, b); spi_bit(1'b0, b); spi_bit(1'b1, b);
    frame_end();
    tests++; if (regs_o !== 40'h22_11_80_A5_5A) begin fails++; $display("FAIL partial_regs: got %h expected 221180a55a", regs_o); end
    tests++; if (strobe_log.size() - s0 != 1 || strobe_log[s0] !== 5'b00001) begin fails++; $display("FAIL partial_strobe: got %0d entries expected one 00001", strobe_log.size() - s0); end
    tests++; if (err_total - e0 != 1) begin fails++; $display("FAIL partial_err: got %0d expected 1", err_total - e0); end
  endtask

  task automatic test_reset_mid_frame();
    int e0, s0;
    logic [7:0] r;
    logic b;
    e0 = err_total;
    frame_start(1'b1, 7'h04);
    spi_bit(1'b0, b); spi_bit(1'b1, b); spi_bit(1'b1, b); spi_bit(1'b1, b);
    rst_n = 1'b0;
    wait_clk(2);
    spi.ncs = 1'b1; spi.sclk = 1'b0; spi.copi = 1'b0;
    wait_clk(3);
    tests++; if (regs_o !== 40'h0) begin fails++; $display("FAIL midrst_regs: got %h expected 0", regs_o); end
    tests++; if (state_o !== IDLE) begin fails++; $display("FAIL midrst_state: got %0d expected %0d", state_o, IDLE); end
    rst_n = 1'b1;
    wait_clk(5);
    tests++; if (state_o !== IDLE) begin fails++; $display("FAIL midrst_release_state: got %0d expected %0d", state_o, IDLE); end
    s0 = strobe_log.size();
    frame_start(1'b1, 7'h04); spi_word(8'h77, r); frame_end();
    tests++; if (regs_o !== 40'h77_00_00_00_00) begin fails++; $display("FAIL midrst_rewrite: got %h expected 7700000000", regs_o); end
    tests++; if (strobe_log.size() - s0 != 1 || strobe_log[s0] !== 5'b10000) begin fails++; $display("FAIL midrst_strobe: got %0d entries expected one 10000", strobe_log.size() - s0); end
    tests++; if (err_total - e0 != 0) begin fails++; $display("FAIL midrst_err: got %0d expected 0", err_total - e0); end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_burst_wrap();
    test_write_latency();
    test_read_burst();
    test_read_wrap();
    test_out_of_range();
    test_partial_word();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
